// File: rtl/uart_serdes.sv
// Full-duplex 8N1 UART: independent TX and RX sub-blocks sharing clk, rst_n and CLKS_PER_BIT.
// Bit timing uses down-counters that reload at CLKS_PER_BIT-1 and advance on terminal count 0.
//
// TX state | meaning
// ---------+------------------------------------------------
// TX_IDLE  | line high, waiting for flush
// TX_START | driving start bit (0)
// TX_DATA  | shifting out data bits, LSB first
// TX_STOP  | driving stop bit (1) for a full bit time
//
// RX state | meaning
// ---------+------------------------------------------------
// RX_IDLE  | waiting for synchronized line low
// RX_START | counting to mid start bit, re-checking for glitch
// RX_DATA  | sampling data bits mid-bit, LSB first
// RX_STOP  | sampling stop bit; publishes byte if it is 1
// RX_BREAK | framing error, waiting for line to return high
module uart_serdes #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_rx,
  output logic [7:0] incoming,
  output logic       ready,
  input  logic [7:0] outgoing,
  input  logic       flush,
  output logic       serial_tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  tx_state_t     tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic [2:0]    tx_idx, tx_idx_d;
  logic          serial_tx_d, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_shift  <= '0;
      tx_idx    <= '0;
      serial_tx <= 1'b1;
      busy      <= 1'b0;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_shift  <= tx_shift_d;
      tx_idx    <= tx_idx_d;
      serial_tx <= serial_tx_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt;
    tx_shift_d  = tx_shift;
    tx_idx_d    = tx_idx;
    serial_tx_d = serial_tx;
    busy_d      = busy;
    case (tx_state)
      TX_IDLE: begin
        serial_tx_d = 1'b1;
        busy_d      = 1'b0;
        if (flush) begin
          tx_shift_d  = outgoing;
          tx_cnt_d    = BIT_LAST;
          tx_idx_d    = 3'd0;
          serial_tx_d = 1'b0;
          busy_d      = 1'b1;
          tx_state_d  = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_ZERO) begin
          tx_cnt_d    = BIT_LAST;
          tx_idx_d    = 3'd0;
          serial_tx_d = tx_shift[0];
          tx_state_d  = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_ZERO) begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx == 3'd7) begin
            serial_tx_d = 1'b1;
            tx_state_d  = TX_STOP;
          end else begin
            // bit 0 of the shift register is always the bit currently on the line
            tx_shift_d  = {1'b0, tx_shift[7:1]};
            serial_tx_d = tx_shift[1];
            tx_idx_d    = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_ZERO) begin
          serial_tx_d = 1'b1;
          busy_d      = 1'b0;
          tx_state_d  = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      default: begin
        serial_tx_d = 1'b1;
        busy_d      = 1'b0;
        tx_state_d  = TX_IDLE;
      end
    endcase
  end

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic [2:0]    rx_idx, rx_idx_d;
  logic [7:0]    incoming_d;
  logic          ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_idx   <= '0;
      incoming <= 8'h00;
      ready    <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_shift <= rx_shift_d;
      rx_idx   <= rx_idx_d;
      incoming <= incoming_d;
      ready    <= ready_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_shift_d = rx_shift;
    rx_idx_d   = rx_idx;
    incoming_d = incoming;
    ready_d    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_ZERO) begin
          if (rx_sync) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = BIT_LAST;
            rx_idx_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_ZERO) begin
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_idx == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_ZERO) begin
          if (rx_sync) begin
            incoming_d = rx_shift;
            ready_d    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_sync) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_serdes.sv
// Self-checking bench for uart_serdes: TX waveforms, loopback, direct RX frames, glitch,
// framing error and mid-frame reset, with a small-CPB instance and a default-CPB loopback instance.
module tb_uart_serdes;
  localparam int CPB     = 8;
  localparam int CPB_BIG = 1250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_rx, ready, flush, serial_tx, busy;
  logic [7:0] incoming, outgoing;
  logic       lb, rx_drv;

  logic       tx_b, ready_b, flush_b, busy_b;
  logic [7:0] in_b, out_b;

  always #5 clk = ~clk;

  assign serial_rx = lb ? serial_tx : rx_drv;

  uart_serdes #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_rx (serial_rx),
    .incoming  (incoming),
    .ready     (ready),
    .outgoing  (outgoing),
    .flush     (flush),
    .serial_tx (serial_tx),
    .busy      (busy)
  );

  uart_serdes #(.CLKS_PER_BIT(CPB_BIG)) dut_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_rx (tx_b),
    .incoming  (in_b),
    .ready     (ready_b),
    .outgoing  (out_b),
    .flush     (flush_b),
    .serial_tx (tx_b),
    .busy      (busy_b)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         inject;
    logic [7:0] alt;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ready;
  } rx_vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_in;
  tx_vec_t    tx_tab[$];
  rx_vec_t    rx_tab[$];
  int         bcnt, rcnt, rcyc, n0;
  logic       busy_after;
  logic [7:0] rbyte, rnd;
  logic       rnd_stop;

  always @(negedge clk) begin
    if (ready) got_q.push_back(incoming);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame on the wire, index 0 first: start 0, data LSB first, stop 1.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic tx_vec_t mk_tx(input logic [7:0] d, input logic [9:0] f,
                                    input int inj, input logic [7:0] a);
    tx_vec_t v;
    v.data = d; v.frame = f; v.inject = inj; v.alt = a;
    return v;
  endfunction

  function automatic rx_vec_t mk_rx(input logic [7:0] d, input logic s, input logic r);
    rx_vec_t v;
    v.data = d; v.stop = s; v.exp_ready = r;
    return v;
  endfunction

  // Called at a negedge; flush is sampled by the following posedge (T0).
  task automatic send_frame(input logic [7:0] b, input logic [9:0] fr,
                            input int inject, input logic [7:0] alt);
    outgoing = b;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("tx_line", serial_tx, fr[k / CPB]);
      chk("tx_busy", busy, 1);
      if (k == inject) begin
        flush    = 1'b1;
        outgoing = alt;
      end
      if (k == inject + 1) flush = 1'b0;
      @(negedge clk);
    end
    chk("tx_busy_end", busy, 0);
    chk("tx_gap_line", serial_tx, 1);
    if (inject >= 0) begin
      for (int k = 0; k < 2 * CPB; k++) begin
        @(negedge clk);
        chk("no_extra_frame", {busy, serial_tx}, 2'b01);
      end
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(name, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; outgoing = 8'h00; rx_drv = 1'b1; lb = 1'b0;
    flush_b = 1'b0; out_b = 8'h00; exp_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_serial_tx", serial_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_incoming", incoming, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_big_tx", tx_b, 1);
    chk("rst_big_busy", busy_b, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Default-rate loopback of 8'hD5.
    out_b = 8'hD5; flush_b = 1'b1;
    @(negedge clk);
    flush_b = 1'b0;
    bcnt = 0; rcnt = 0; rcyc = -1; rbyte = 8'h00; busy_after = 1'b1;
    for (int k = 0; k < 12600; k++) begin
      if (busy_b) bcnt++;
      if (k == 12500) busy_after = busy_b;
      if (ready_b) begin
        rcnt++; rcyc = k; rbyte = in_b;
      end
      @(negedge clk);
    end
    chk("big_busy_len", bcnt, 12500);
    chk("big_busy_fall", busy_after, 0);
    chk("big_ready_cnt", rcnt, 1);
    chk("big_byte", rbyte, 8'hD5);
    chk("big_latency", (rcyc >= 11876 && rcyc <= 11878), 1);

    // TX waveforms in loopback: fixed frames back-to-back, an ignored flush, then random bytes.
    lb = 1'b1;
    got_q.delete();
    tx_tab.push_back(mk_tx(8'hA3, 10'h346, -1, 8'h00));
    tx_tab.push_back(mk_tx(8'h00, 10'h200, -1, 8'h00));
    tx_tab.push_back(mk_tx(8'hFF, 10'h3FE, -1, 8'h00));
    tx_tab.push_back(mk_tx(8'h55, 10'h2AA, -1, 8'h00));
    tx_tab.push_back(mk_tx(8'h96, 10'h32C, 35, 8'h69));
    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      tx_tab.push_back(mk_tx(rnd, frame_of(rnd), -1, 8'h00));
    end
    foreach (tx_tab[i]) begin
      send_frame(tx_tab[i].data, tx_tab[i].frame, tx_tab[i].inject, tx_tab[i].alt);
      exp_q.push_back(tx_tab[i].data);
      exp_in = tx_tab[i].data;
    end
    repeat (2 * CPB) @(negedge clk);
    check_rx("loop_rx");
    chk("loop_incoming", incoming, exp_in);

    // Direct RX: a short glitch, then table of frames including framing errors.
    lb = 1'b0;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_ready", got_q.size(), 0);
    chk("glitch_incoming", incoming, exp_in);

    rx_tab.push_back(mk_rx(8'hA5, 1'b0, 1'b0));
    rx_tab.push_back(mk_rx(8'h3C, 1'b1, 1'b1));
    rx_tab.push_back(mk_rx(8'h00, 1'b0, 1'b0));
    rx_tab.push_back(mk_rx(8'hC3, 1'b1, 1'b1));
    for (int i = 0; i < 5; i++) begin
      rnd      = 8'($urandom);
      rnd_stop = ($urandom_range(0, 3) != 0);
      rx_tab.push_back(mk_rx(rnd, rnd_stop, rnd_stop));
    end
    foreach (rx_tab[i]) begin
      got_q.delete();
      drive_rx(rx_tab[i].data, rx_tab[i].stop);
      if (rx_tab[i].stop) exp_in = rx_tab[i].data;
      chk("rx_ready_cnt", got_q.size(), {31'd0, rx_tab[i].exp_ready});
      chk("rx_incoming", incoming, exp_in);
    end
    got_q.delete();

    // Reset in the middle of a data bit aborts both directions at once.
    lb = 1'b1;
    outgoing = 8'h96; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", serial_tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_incoming", incoming, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    exp_in = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    chk("mid_rst_no_ready", got_q.size(), 0);
    send_frame(8'h3C, frame_of(8'h3C), -1, 8'h00);
    exp_q.push_back(8'h3C);
    exp_in = 8'h3C;
    repeat (2 * CPB) @(negedge clk);
    check_rx("post_rst_rx");
    chk("post_rst_incoming", incoming, exp_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
